// File: rtl/data_mem_if.sv
// Memory-stage request bus between the pipeline and the data-memory responder.
// The initiator drives the request and address fields; the responder drives the result fields.
interface data_mem_if #(
   parameter int DataWidth = 32
);
   logic                 request;
   logic                 we_re;
   logic [3:0]           mask;
   logic [DataWidth-1:0] addr;
   logic [DataWidth-1:0] wdata;
   logic [DataWidth-1:0] rdata;
   logic                 data_valid;
   logic                 busy;

   modport master (
      output request, we_re, mask, addr, wdata,
      input  rdata, data_valid, busy
   );

   modport slave (
      input  request, we_re, mask, addr, wdata,
      output rdata, data_valid, busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory for the memory stage: one load/store in flight,
// byte-enable stores, completion pulse on data_valid after Latency cycles.
module data_mem_responder #(
   parameter int DataWidth = 32,
   parameter int Depth     = 256,
   parameter int Latency   = 2
) (
   input logic        clk,
   input logic        rst,
   data_mem_if.slave  bus
);
   localparam int       IdxW    = $clog2(Depth);
   localparam int       Lanes   = DataWidth / 8;
   localparam bit       Direct  = (Latency == 1);
   localparam bit [3:0] CntLoad = 4'(Latency - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 cap_we;
   logic [3:0]           cap_mask;
   logic [IdxW-1:0]      cap_idx;
   logic [DataWidth-1:0] cap_wdata;
   logic [DataWidth-1:0] rdata_q;
   logic [DataWidth-1:0] mem [Depth];

   logic                 accept;
   logic                 load_rd;
   logic [IdxW-1:0]      rd_idx;
   logic [IdxW-1:0]      req_idx;

   // Upper address bits alias modulo Depth and the byte offset is the initiator's concern.
   assign req_idx = bus.addr[IdxW+1:2];
   wire unused_addr = ^{bus.addr[DataWidth-1:IdxW+2], bus.addr[1:0]};

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      load_rd = 1'b0;
      rd_idx  = cap_idx;
      unique case (state_q)
         IDLE: begin
            if (bus.request) begin
               accept = 1'b1;
               cnt_d  = CntLoad;
               if (Direct) begin
                  // Captured index is not registered yet, so read with the live one.
                  state_d = RESP;
                  load_rd = !bus.we_re;
                  rd_idx  = req_idx;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
               load_rd = !cap_we;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cap_we    <= 1'b0;
         cap_mask  <= '0;
         cap_idx   <= '0;
         cap_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            cap_we    <= bus.we_re;
            cap_mask  <= bus.mask;
            cap_idx   <= req_idx;
            cap_wdata <= bus.wdata;
         end
         if (load_rd) rdata_q <= mem[rd_idx];
      end
   end

   // NOTE: the array has no reset; contents survive rst and map onto plain RAM.
   // An async reset forces state_q out of RESP, so an abandoned store never lands.
   always_ff @(posedge clk) begin
      if (state_q == RESP && cap_we) begin
         for (int i = 0; i < Lanes; i++) begin
            if (cap_mask[i]) mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
         end
      end
   end

   assign bus.rdata      = rdata_q;
   assign bus.data_valid = (state_q == RESP);
   assign bus.busy       = (state_q != IDLE);
endmodule
